// File: rtl/bucket_drain.sv
// bucket_drain
//   Read-side counterpart of the sketch bucket updater. After a measurement
//   epoch it walks the bucket RAM from address 0 to DEPTH-1. Every non-empty
//   entry ({id, count}, all-zero meaning empty) is emitted on a valid/ready
//   stream. When clear_en is latched with start, each word read is written
//   back as zero so the next epoch starts clean.
//
// Ports
//   clk, rst           single clock, synchronous active-high reset
//   start, clear_en    pass request pulse; clear_en is latched with it
//   busy, done         pass in progress / one-cycle end-of-pass pulse
//   entry_cnt          non-empty entries emitted in the last pass
//   ram_rden/raddr     read port, data returns on ram_rdata one cycle later
//   ram_wren/waddr/wdata  clear write port (wdata is always zero)
//   out_valid/ready    output stream handshake
//   out_addr/id/count  bucket index and contents of the head beat
module bucket_drain #(
  parameter int RAM_PTR    = 10,
  parameter int FIFO_DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               clear_en,
  output logic               busy,
  output logic               done,
  output logic [RAM_PTR:0]   entry_cnt,
  output logic               ram_rden,
  output logic [RAM_PTR-1:0] ram_raddr,
  input  logic [63:0]        ram_rdata,
  output logic               ram_wren,
  output logic [RAM_PTR-1:0] ram_waddr,
  output logic [63:0]        ram_wdata,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [RAM_PTR-1:0] out_addr,
  output logic [31:0]        out_id,
  output logic [31:0]        out_count
);

  localparam int PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W   = $clog2(FIFO_DEPTH + 2);
  localparam int ENTRY_W = RAM_PTR + 64;
  localparam logic [RAM_PTR-1:0] LAST_ADDR = '1;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DRAIN,
    FINISH
  } state_t;

  state_t             state_q, state_d;
  logic [RAM_PTR-1:0] rd_addr_q;
  logic               rd_pending_q;
  logic [RAM_PTR-1:0] ret_addr_q;
  logic               clear_q;
  logic [RAM_PTR:0]   entry_cnt_q;

  logic [ENTRY_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   head_q, tail_q;
  logic [CNT_W-1:0]   fifo_cnt_q;

  logic               start_ok;
  logic               push;
  logic               pop;
  logic [CNT_W-1:0]   credit_used;
  logic [ENTRY_W-1:0] head_entry;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(FIFO_DEPTH - 1)) return '0;
    return p + PTR_W'(1);
  endfunction

  // A returned word occupies a credit until it is either dropped (empty) or
  // leaves the FIFO, so outstanding reads plus buffered beats never exceed the
  // FIFO size. Only registered terms feed ram_rden, keeping out_ready off the
  // read-enable path.
  assign start_ok    = start && (state_q == IDLE);
  assign credit_used = fifo_cnt_q + CNT_W'(rd_pending_q);
  assign push        = rd_pending_q && (ram_rdata != 64'b0);
  assign out_valid   = (fifo_cnt_q != '0);
  assign pop         = out_valid && out_ready;

  assign head_entry = fifo_mem[head_q];
  assign out_addr   = head_entry[ENTRY_W-1:64];
  assign out_id     = head_entry[63:32];
  assign out_count  = head_entry[31:0];

  // Every returned word is cleared, empty or not, so a read racing a late
  // updater write still leaves the bucket zeroed.
  assign ram_raddr = rd_addr_q;
  assign ram_wren  = rd_pending_q && clear_q;
  assign ram_waddr = ret_addr_q;
  assign ram_wdata = 64'b0;

  assign busy      = (state_q != IDLE);
  assign entry_cnt = entry_cnt_q;

  // Next-state and read-issue logic. The pass moves to DRAIN once the last
  // address has been issued, and only finishes when nothing is in flight and
  // the output buffer has emptied.
  always_comb begin
    state_d  = state_q;
    ram_rden = 1'b0;
    done     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) state_d = SCAN;
      end
      SCAN: begin
        ram_rden = (credit_used < CNT_W'(FIFO_DEPTH));
        if (ram_rden && (rd_addr_q == LAST_ADDR)) state_d = DRAIN;
      end
      DRAIN: begin
        if (!rd_pending_q && (fifo_cnt_q == '0)) state_d = FINISH;
      end
      FINISH: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, address walk, read tracking and the emitted-entry counter. The
  // address counter saturates at the last address rather than wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      rd_addr_q    <= '0;
      rd_pending_q <= 1'b0;
      ret_addr_q   <= '0;
      clear_q      <= 1'b0;
      entry_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      rd_pending_q <= ram_rden;
      if (ram_rden) ret_addr_q <= rd_addr_q;
      if (start_ok) begin
        rd_addr_q <= '0;
        clear_q   <= clear_en;
      end else if (ram_rden && (rd_addr_q != LAST_ADDR)) begin
        rd_addr_q <= rd_addr_q + RAM_PTR'(1);
      end
      if (start_ok) entry_cnt_q <= '0;
      else if (push) entry_cnt_q <= entry_cnt_q + (RAM_PTR + 1)'(1);
    end
  end

  // Output buffer pointers; reset discards any buffered beats.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q     <= '0;
      tail_q     <= '0;
      fifo_cnt_q <= '0;
    end else begin
      if (push) tail_q <= ptr_inc(tail_q);
      if (pop) head_q <= ptr_inc(head_q);
      case ({push, pop})
        2'b10:   fifo_cnt_q <= fifo_cnt_q + CNT_W'(1);
        2'b01:   fifo_cnt_q <= fifo_cnt_q - CNT_W'(1);
        default: fifo_cnt_q <= fifo_cnt_q;
      endcase
    end
  end

  // Buffer storage needs no reset; validity comes from the count.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[tail_q] <= {ret_addr_q, ram_rdata};
  end

endmodule

// File: tb/tb_bucket_drain.sv
// tb_bucket_drain
//   Directed bench for bucket_drain. Two instances share the control inputs:
//   a 16-entry one for the directed scenarios and a 64-entry one for the
//   randomised stream. Each has a behavioural one-cycle-latency RAM.
module tb_bucket_drain;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic clear_en = 1'b0;
  logic out_ready = 1'b0;
  logic sel = 1'b0;

  // RAM load port driven by the bench
  logic        ld_en = 1'b0;
  logic        ld_clr = 1'b0;
  logic        ld_sel = 1'b0;
  logic [5:0]  ld_addr = '0;
  logic [63:0] ld_data = '0;

  logic [63:0] mem_a [16];
  logic [63:0] mem_b [64];

  logic        a_busy, a_done, a_rden, a_wren, a_valid;
  logic [4:0]  a_entry_cnt;
  logic [3:0]  a_raddr, a_waddr, a_out_addr;
  logic [63:0] a_rdata, a_wdata;
  logic [31:0] a_out_id, a_out_count;

  logic        b_busy, b_done, b_rden, b_wren, b_valid;
  logic [6:0]  b_entry_cnt;
  logic [5:0]  b_raddr, b_waddr, b_out_addr;
  logic [63:0] b_rdata, b_wdata;
  logic [31:0] b_out_id, b_out_count;

  logic        m_busy, m_done, m_rden, m_wren, m_valid;
  logic [6:0]  m_entry_cnt;
  logic [5:0]  m_raddr, m_addr;
  logic [31:0] m_id, m_count;

  int checks = 0;
  int errors = 0;

  logic [5:0]  got_addr [$];
  logic [31:0] got_id [$];
  logic [31:0] got_cnt [$];
  logic [5:0]  exp_addr [$];
  logic [31:0] exp_id [$];
  logic [31:0] exp_cnt [$];
  int          done_k, done_seen, first_valid_k, first_rden_k, rden_hold, unstable;
  logic [5:0]  first_raddr;

  always #5 clk = ~clk;

  bucket_drain #(.RAM_PTR(4), .FIFO_DEPTH(2)) dut_a (
    .clk(clk), .rst(rst), .start(start & ~sel), .clear_en(clear_en),
    .busy(a_busy), .done(a_done), .entry_cnt(a_entry_cnt),
    .ram_rden(a_rden), .ram_raddr(a_raddr), .ram_rdata(a_rdata),
    .ram_wren(a_wren), .ram_waddr(a_waddr), .ram_wdata(a_wdata),
    .out_valid(a_valid), .out_ready(out_ready), .out_addr(a_out_addr),
    .out_id(a_out_id), .out_count(a_out_count)
  );

  bucket_drain #(.RAM_PTR(6), .FIFO_DEPTH(2)) dut_b (
    .clk(clk), .rst(rst), .start(start & sel), .clear_en(clear_en),
    .busy(b_busy), .done(b_done), .entry_cnt(b_entry_cnt),
    .ram_rden(b_rden), .ram_raddr(b_raddr), .ram_rdata(b_rdata),
    .ram_wren(b_wren), .ram_waddr(b_waddr), .ram_wdata(b_wdata),
    .out_valid(b_valid), .out_ready(out_ready), .out_addr(b_out_addr),
    .out_id(b_out_id), .out_count(b_out_count)
  );

  assign m_busy      = sel ? b_busy : a_busy;
  assign m_done      = sel ? b_done : a_done;
  assign m_rden      = sel ? b_rden : a_rden;
  assign m_wren      = sel ? b_wren : a_wren;
  assign m_valid     = sel ? b_valid : a_valid;
  assign m_entry_cnt = sel ? b_entry_cnt : {2'b0, a_entry_cnt};
  assign m_raddr     = sel ? b_raddr : {2'b0, a_raddr};
  assign m_addr      = sel ? b_out_addr : {2'b0, a_out_addr};
  assign m_id        = sel ? b_out_id : a_out_id;
  assign m_count     = sel ? b_out_count : a_out_count;

  // Behavioural RAMs: bench loads take priority over DUT clears
  always @(posedge clk) begin
    if (ld_clr && !ld_sel) begin
      for (int i = 0; i < 16; i++) mem_a[i] <= 64'b0;
    end else if (ld_en && !ld_sel) begin
      mem_a[ld_addr[3:0]] <= ld_data;
    end else if (a_wren) begin
      mem_a[a_waddr] <= a_wdata;
    end
    if (a_rden) a_rdata <= mem_a[a_raddr];
  end

  always @(posedge clk) begin
    if (ld_clr && ld_sel) begin
      for (int i = 0; i < 64; i++) mem_b[i] <= 64'b0;
    end else if (ld_en && ld_sel) begin
      mem_b[ld_addr] <= ld_data;
    end else if (b_wren) begin
      mem_b[b_waddr] <= b_wdata;
    end
    if (b_rden) b_rdata <= mem_b[b_raddr];
  end

  task automatic clear_ram(input logic which);
    @(negedge clk);
    ld_clr = 1'b1;
    ld_sel = which;
    @(negedge clk);
    ld_clr = 1'b0;
  endtask

  task automatic load_word(input logic which, input int addr, input logic [63:0] data);
    @(negedge clk);
    ld_en   = 1'b1;
    ld_sel  = which;
    ld_addr = addr[5:0];
    ld_data = data;
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  // Runs one pass on the selected instance and records the stream.
  // mode 0: ready held high; 1: ready low for the first 'hold' cycles; 2: random.
  task automatic run_pass(input logic clr, input int mode, input int hold, input int limit);
    logic        pv, pr;
    logic [5:0]  pa;
    logic [31:0] pid, pcnt;
    int          rden_total;
    got_addr.delete();
    got_id.delete();
    got_cnt.delete();
    done_k = 0; done_seen = 0; first_valid_k = 0; first_rden_k = 0;
    rden_hold = 0; unstable = 0; rden_total = 0; first_raddr = '1;
    pv = 1'b0; pr = 1'b0; pa = '0; pid = '0; pcnt = '0;
    @(negedge clk);
    start     = 1'b1;
    clear_en  = clr;
    out_ready = (mode == 0);
    for (int k = 1; k <= limit; k++) begin
      @(negedge clk);
      start    = 1'b0;
      clear_en = 1'b0;
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = (k > hold);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      if (m_rden) begin
        if (rden_total == 0) begin
          first_raddr  = m_raddr;
          first_rden_k = k;
        end
        rden_total++;
        if (k <= hold) rden_hold++;
      end
      if (m_valid && first_valid_k == 0) first_valid_k = k;
      if (pv && !pr) begin
        if (!m_valid || m_addr !== pa || m_id !== pid || m_count !== pcnt) unstable++;
      end
      if (m_valid && out_ready) begin
        got_addr.push_back(m_addr);
        got_id.push_back(m_id);
        got_cnt.push_back(m_count);
      end
      pv = m_valid; pr = out_ready; pa = m_addr; pid = m_id; pcnt = m_count;
      if (m_done) begin
        done_seen++;
        done_k = k;
        break;
      end
    end
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({a_busy, a_done, a_rden, a_wren, a_valid} !== 5'b0) begin
      errors++;
      $display("[TB] FAIL reset_a_ctrl: got %b expected 00000", {a_busy, a_done, a_rden, a_wren, a_valid});
    end
    checks++;
    if ({b_busy, b_done, b_rden, b_wren, b_valid} !== 5'b0) begin
      errors++;
      $display("[TB] FAIL reset_b_ctrl: got %b expected 00000", {b_busy, b_done, b_rden, b_wren, b_valid});
    end
    checks++;
    if (a_entry_cnt !== 5'd0 || b_entry_cnt !== 7'd0) begin
      errors++;
      $display("[TB] FAIL reset_entry_cnt: got %0d/%0d expected 0/0", a_entry_cnt, b_entry_cnt);
    end
    rst = 1'b0;
  endtask

  task automatic test_empty_ram();
    sel = 1'b0;
    clear_ram(1'b0);
    run_pass(1'b0, 0, 0, 100);
    checks++;
    if (done_seen !== 1 || done_k !== 19) begin
      errors++;
      $display("[TB] FAIL empty_done_cycle: got seen=%0d at T+%0d expected 1 at T+19", done_seen, done_k);
    end
    checks++;
    if (first_rden_k !== 1 || first_raddr !== 6'd0) begin
      errors++;
      $display("[TB] FAIL empty_first_read: got T+%0d addr %0d expected T+1 addr 0", first_rden_k, first_raddr);
    end
    checks++;
    if (got_addr.size() !== 0 || first_valid_k !== 0) begin
      errors++;
      $display("[TB] FAIL empty_no_beats: got %0d beats expected 0", got_addr.size());
    end
    @(negedge clk);
    checks++;
    if (m_busy !== 1'b0 || m_done !== 1'b0 || m_entry_cnt !== 7'd0) begin
      errors++;
      $display("[TB] FAIL empty_after_done: got busy=%b done=%b cnt=%0d expected 0 0 0", m_busy, m_done, m_entry_cnt);
    end
  endtask

  task automatic test_basic_stream();
    sel = 1'b0;
    clear_ram(1'b0);
    load_word(1'b0, 3, {32'hA5A50001, 32'd7});
    load_word(1'b0, 15, {32'h00000002, 32'd1});
    for (int pass = 0; pass < 2; pass++) begin
      run_pass(1'b0, 0, 0, 200);
      checks++;
      if (done_seen !== 1) begin
        errors++;
        $display("[TB] FAIL basic_done pass %0d: got %0d expected 1", pass, done_seen);
      end
      checks++;
      if (got_addr.size() !== 2) begin
        errors++;
        $display("[TB] FAIL basic_beat_count pass %0d: got %0d expected 2", pass, got_addr.size());
      end else begin
        checks++;
        if (got_addr[0] !== 6'd3 || got_id[0] !== 32'hA5A50001 || got_cnt[0] !== 32'd7) begin
          errors++;
          $display("[TB] FAIL basic_beat0 pass %0d: got (%0d,%h,%0d) expected (3,a5a50001,7)", pass, got_addr[0], got_id[0], got_cnt[0]);
        end
        checks++;
        if (got_addr[1] !== 6'd15 || got_id[1] !== 32'h2 || got_cnt[1] !== 32'd1) begin
          errors++;
          $display("[TB] FAIL basic_beat1 pass %0d: got (%0d,%h,%0d) expected (15,2,1)", pass, got_addr[1], got_id[1], got_cnt[1]);
        end
      end
      @(negedge clk);
      checks++;
      if (m_entry_cnt !== 7'd2) begin
        errors++;
        $display("[TB] FAIL basic_entry_cnt pass %0d: got %0d expected 2", pass, m_entry_cnt);
      end
      checks++;
      if (mem_a[3] !== {32'hA5A50001, 32'd7} || mem_a[15] !== {32'h2, 32'd1}) begin
        errors++;
        $display("[TB] FAIL noclear_ram_kept pass %0d: got %h %h", pass, mem_a[3], mem_a[15]);
      end
    end
  endtask

  task automatic test_backpressure();
    int bad;
    sel = 1'b0;
    for (int i = 0; i < 16; i++) load_word(1'b0, i, {32'hC0DE0000 + 32'(i), 32'd100 + 32'(i)});
    run_pass(1'b0, 1, 20, 300);
    checks++;
    if (rden_hold !== 2) begin
      errors++;
      $display("[TB] FAIL bp_outstanding: got %0d reads while stalled expected 2", rden_hold);
    end
    checks++;
    if (first_valid_k !== 3) begin
      errors++;
      $display("[TB] FAIL bp_first_valid: got T+%0d expected T+3", first_valid_k);
    end
    checks++;
    if (unstable !== 0) begin
      errors++;
      $display("[TB] FAIL bp_hold_stable: got %0d changes expected 0", unstable);
    end
    checks++;
    if (done_seen !== 1 || got_addr.size() !== 16) begin
      errors++;
      $display("[TB] FAIL bp_beat_count: got done=%0d beats=%0d expected 1 and 16", done_seen, got_addr.size());
    end else begin
      bad = 0;
      for (int i = 0; i < 16; i++) begin
        if (got_addr[i] !== 6'(i) || got_id[i] !== 32'hC0DE0000 + 32'(i) || got_cnt[i] !== 32'd100 + 32'(i)) bad++;
      end
      checks++;
      if (bad !== 0) begin
        errors++;
        $display("[TB] FAIL bp_order: got %0d wrong beats expected 0", bad);
      end
    end
    @(negedge clk);
    checks++;
    if (m_entry_cnt !== 7'd16) begin
      errors++;
      $display("[TB] FAIL bp_entry_cnt: got %0d expected 16", m_entry_cnt);
    end
  endtask

  task automatic test_clear();
    int nonzero;
    sel = 1'b0;
    clear_ram(1'b0);
    load_word(1'b0, 3, {32'hA5A50001, 32'd7});
    load_word(1'b0, 15, {32'h00000002, 32'd1});
    run_pass(1'b1, 0, 0, 200);
    checks++;
    if (done_seen !== 1 || got_addr.size() !== 2) begin
      errors++;
      $display("[TB] FAIL clear_first_pass: got done=%0d beats=%0d expected 1 and 2", done_seen, got_addr.size());
    end
    @(negedge clk);
    nonzero = 0;
    for (int i = 0; i < 16; i++) if (mem_a[i] !== 64'b0) nonzero++;
    checks++;
    if (nonzero !== 0) begin
      errors++;
      $display("[TB] FAIL clear_ram_zero: got %0d non-zero words expected 0", nonzero);
    end
    run_pass(1'b0, 0, 0, 200);
    checks++;
    if (done_seen !== 1 || got_addr.size() !== 0) begin
      errors++;
      $display("[TB] FAIL clear_second_pass: got done=%0d beats=%0d expected 1 and 0", done_seen, got_addr.size());
    end
    @(negedge clk);
    checks++;
    if (m_entry_cnt !== 7'd0) begin
      errors++;
      $display("[TB] FAIL clear_entry_cnt: got %0d expected 0", m_entry_cnt);
    end
  endtask

  task automatic test_start_while_busy();
    int dones = 0, reads = 0, wrens = 0, busy_after = 0, dk = 0;
    logic [5:0] last = '0;
    int order_bad = 0;
    sel = 1'b0;
    clear_ram(1'b0);
    @(negedge clk);
    out_ready = 1'b1;
    start     = 1'b1;
    clear_en  = 1'b0;
    for (int k = 1; k <= 24; k++) begin
      @(negedge clk);
      start    = (k == 5) || (k == 19);
      clear_en = (k == 5);
      if (m_rden) begin
        if (reads > 0 && m_raddr <= last) order_bad++;
        last = m_raddr;
        reads++;
      end
      if (m_wren) wrens++;
      if (m_done) begin
        dones++;
        dk = k;
      end
      if (k >= 20 && m_busy) busy_after++;
    end
    start    = 1'b0;
    clear_en = 1'b0;
    checks++;
    if (dones !== 1 || dk !== 19) begin
      errors++;
      $display("[TB] FAIL restart_done: got %0d dones last at T+%0d expected 1 at T+19", dones, dk);
    end
    checks++;
    if (reads !== 16 || order_bad !== 0) begin
      errors++;
      $display("[TB] FAIL restart_reads: got %0d reads %0d out of order expected 16 and 0", reads, order_bad);
    end
    checks++;
    if (wrens !== 0) begin
      errors++;
      $display("[TB] FAIL restart_clear_latch: got %0d writes expected 0", wrens);
    end
    checks++;
    if (busy_after !== 0) begin
      errors++;
      $display("[TB] FAIL start_on_done: got %0d busy cycles expected 0", busy_after);
    end
  endtask

  task automatic test_reset_mid_pass();
    sel = 1'b0;
    clear_ram(1'b0);
    load_word(1'b0, 5, {32'h00000055, 32'd5});
    load_word(1'b0, 10, {32'h0000AAAA, 32'd10});
    load_word(1'b0, 12, {32'h0000CCCC, 32'd12});
    @(negedge clk);
    out_ready = 1'b0;
    start     = 1'b1;
    clear_en  = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      start    = 1'b0;
      clear_en = 1'b0;
      if (k == 8) begin
        checks++;
        if (m_valid !== 1'b1 || m_addr !== 6'd5) begin
          errors++;
          $display("[TB] FAIL midrst_pending_beat: got valid=%b addr=%0d expected 1 and 5", m_valid, m_addr);
        end
        rst = 1'b1;
      end
    end
    @(negedge clk);
    checks++;
    if ({m_busy, m_valid, m_wren, m_done} !== 4'b0 || m_entry_cnt !== 7'd0) begin
      errors++;
      $display("[TB] FAIL midrst_state: got %b cnt=%0d expected 0000 cnt=0", {m_busy, m_valid, m_wren, m_done}, m_entry_cnt);
    end
    rst = 1'b0;
    checks++;
    if (mem_a[5] !== 64'b0) begin
      errors++;
      $display("[TB] FAIL midrst_cleared_word: got %h expected 0", mem_a[5]);
    end
    run_pass(1'b0, 0, 0, 200);
    checks++;
    if (first_raddr !== 6'd0 || first_rden_k !== 1) begin
      errors++;
      $display("[TB] FAIL midrst_rescan: got addr %0d at T+%0d expected 0 at T+1", first_raddr, first_rden_k);
    end
    checks++;
    if (done_seen !== 1 || got_addr.size() !== 2) begin
      errors++;
      $display("[TB] FAIL midrst_beats: got done=%0d beats=%0d expected 1 and 2", done_seen, got_addr.size());
    end else begin
      checks++;
      if (got_addr[0] !== 6'd10 || got_id[0] !== 32'hAAAA || got_addr[1] !== 6'd12 || got_cnt[1] !== 32'd12) begin
        errors++;
        $display("[TB] FAIL midrst_order: got %0d,%0d expected 10,12", got_addr[0], got_addr[1]);
      end
    end
  endtask

  task automatic test_random_stream();
    logic [63:0] w;
    int bad;
    sel = 1'b1;
    clear_ram(1'b1);
    exp_addr.delete();
    exp_id.delete();
    exp_cnt.delete();
    for (int i = 0; i < 64; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        w = {32'($urandom), 32'($urandom) | 32'h1};
        load_word(1'b1, i, w);
        exp_addr.push_back(6'(i));
        exp_id.push_back(w[63:32]);
        exp_cnt.push_back(w[31:0]);
      end
    end
    run_pass(1'b0, 2, 0, 3000);
    checks++;
    if (done_seen !== 1 || got_addr.size() !== exp_addr.size()) begin
      errors++;
      $display("[TB] FAIL rand_beat_count: got done=%0d beats=%0d expected 1 and %0d", done_seen, got_addr.size(), exp_addr.size());
    end else begin
      bad = 0;
      for (int i = 0; i < exp_addr.size(); i++) begin
        if (got_addr[i] !== exp_addr[i] || got_id[i] !== exp_id[i] || got_cnt[i] !== exp_cnt[i]) bad++;
      end
      checks++;
      if (bad !== 0) begin
        errors++;
        $display("[TB] FAIL rand_stream: got %0d wrong beats expected 0", bad);
      end
    end
    @(negedge clk);
    checks++;
    if (m_entry_cnt !== 7'(exp_addr.size())) begin
      errors++;
      $display("[TB] FAIL rand_entry_cnt: got %0d expected %0d", m_entry_cnt, exp_addr.size());
    end
    sel = 1'b0;
  endtask

  initial begin
    test_reset();
    test_empty_ram();
    test_basic_stream();
    test_backpressure();
    test_clear();
    test_start_while_busy();
    test_reset_mid_pass();
    test_random_stream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
